// File: rtl/stream_arb_sched_pkg.sv
// Shared types and defaults for the round-robin stream arbiter.
// Holds the FSM encoding, the 2-bit mode codes and the default geometry.
package stream_arb_sched_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   // Mode codes travel with each beat; the arbiter forwards them untouched.
   localparam logic [1:0] MODE_PASS = 2'd0;
   localparam logic [1:0] MODE_INV  = 2'd1;
   localparam logic [1:0] MODE_SWAP = 2'd2;
   localparam logic [1:0] MODE_ZERO = 2'd3;

   localparam int DEF_N_REQ     = 4;
   localparam int DEF_DW        = 8;
   localparam int DEF_BURST_LEN = 4;

   // Increment a requester index, wrapping from n-1 back to 0.
   function automatic logic [1:0] wrap_inc(input logic [1:0] idx, input int n);
      return (int'(idx) == n - 1) ? 2'd0 : idx + 2'd1;
   endfunction

endpackage

// File: rtl/stream_arb_sched_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr_i,
// scanning upward and wrapping modulo N_REQ.
module rr_pick
   import stream_arb_sched_pkg::*;
#(
   parameter int N_REQ = DEF_N_REQ
) (
   input  logic [N_REQ-1:0] req_i,
   input  logic [1:0]       ptr_i,
   output logic [1:0]       idx_o,
   output logic             any_o
);

   int cand;

   always_comb begin
      idx_o = ptr_i;
      any_o = 1'b0;
      cand  = 0;
      for (int k = 0; k < N_REQ; k++) begin
         cand = (int'(ptr_i) + k) % N_REQ;
         if (!any_o && req_i[cand[1:0]]) begin
            any_o = 1'b1;
            idx_o = cand[1:0];
         end
      end
   end

endmodule

// File: rtl/stream_arb_sched.sv
// Round-robin burst arbiter feeding one registered output stream.
// Handshake: a beat moves on any edge where valid and ready are both high.
module stream_arb_sched
   import stream_arb_sched_pkg::*;
#(
   parameter int N_REQ     = DEF_N_REQ,
   parameter int DW        = DEF_DW,
   parameter int BURST_LEN = DEF_BURST_LEN
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N_REQ-1:0]   req_valid,
   input  logic [N_REQ*DW-1:0] req_data,
   input  logic [2*N_REQ-1:0] req_mode,
   output logic [N_REQ-1:0]   req_ready,
   output logic               valid_out,
   input  logic               ready_in,
   output logic [DW-1:0]      data_out,
   output logic [1:0]         mode_out,
   output logic [1:0]         grant_id,
   output logic               busy
);

   state_t        state_q, state_d;
   logic [1:0]    rr_ptr_q, rr_ptr_d;
   logic [1:0]    grant_q, grant_d;
   logic [3:0]    beat_cnt_q, beat_cnt_d;
   logic          valid_q, valid_d;
   logic [DW-1:0] data_q, data_d;
   logic [1:0]    mode_q, mode_d;

   logic [1:0]    pick_idx;
   logic          pick_any;
   logic          g_valid;
   logic          g_ready;
   logic          xfer;

   rr_pick #(.N_REQ(N_REQ)) u_pick (
      .req_i (req_valid),
      .ptr_i (rr_ptr_q),
      .idx_o (pick_idx),
      .any_o (pick_any)
   );

   // The holder may push whenever the output register is empty or draining.
   assign g_valid = req_valid[grant_q];
   assign g_ready = (state_q == GRANT) && (!valid_q || ready_in);
   assign xfer    = g_valid && g_ready;

   always_comb begin
      req_ready          = '0;
      req_ready[grant_q] = g_ready;
   end

   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      grant_d    = grant_q;
      beat_cnt_d = beat_cnt_q;
      case (state_q)
         IDLE: begin
            if (pick_any) begin
               state_d    = GRANT;
               grant_d    = pick_idx;
               beat_cnt_d = '0;
            end
         end
         GRANT: begin
            if (xfer) beat_cnt_d = beat_cnt_q + 4'd1;
            // Release on a full burst or when the holder withdraws valid.
            if ((xfer && beat_cnt_d == 4'(BURST_LEN)) || !g_valid) begin
               state_d  = IDLE;
               rr_ptr_d = wrap_inc(grant_q, N_REQ);
            end
         end
      endcase
   end

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      mode_d  = mode_q;
      if (xfer) begin
         valid_d = 1'b1;
         data_d  = req_data[int'(grant_q)*DW +: DW];
         mode_d  = req_mode[int'(grant_q)*2 +: 2];
      end else if (valid_q && ready_in) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         rr_ptr_q   <= '0;
         grant_q    <= '0;
         beat_cnt_q <= '0;
         valid_q    <= 1'b0;
         data_q     <= '0;
         mode_q     <= '0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         grant_q    <= grant_d;
         beat_cnt_q <= beat_cnt_d;
         valid_q    <= valid_d;
         data_q     <= data_d;
         mode_q     <= mode_d;
      end
   end

   assign valid_out = valid_q;
   assign data_out  = data_q;
   assign mode_out  = mode_q;
   assign grant_id  = grant_q;
   assign busy      = (state_q == GRANT);

endmodule

// File: tb/tb_stream_arb_sched.sv
// Directed and randomized bench for stream_arb_sched against a
// transaction-level round-robin model with an expected-beat queue.
module tb_stream_arb_sched;

   localparam int N  = 4;
   localparam int DW = 8;
   localparam int BL = 4;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [N-1:0]    req_valid;
   logic [N*DW-1:0] req_data;
   logic [2*N-1:0]  req_mode;
   logic            ready_in;
   logic [N-1:0]    req_ready, req_ready1;
   logic            valid_out, valid_out1;
   logic [DW-1:0]   data_out, data_out1;
   logic [1:0]      mode_out, mode_out1, grant_id, grant_id1;
   logic            busy, busy1;

   stream_arb_sched #(.N_REQ(N), .DW(DW), .BURST_LEN(BL)) u_dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
      .req_mode(req_mode), .req_ready(req_ready), .valid_out(valid_out),
      .ready_in(ready_in), .data_out(data_out), .mode_out(mode_out),
      .grant_id(grant_id), .busy(busy)
   );

   stream_arb_sched #(.N_REQ(N), .DW(DW), .BURST_LEN(1)) u_dut1 (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
      .req_mode(req_mode), .req_ready(req_ready1), .valid_out(valid_out1),
      .ready_in(ready_in), .data_out(data_out1), .mode_out(mode_out1),
      .grant_id(grant_id1), .busy(busy1)
   );

   // ---------------- bench state ----------------
   int n_checks = 0;
   int n_fail   = 0;

   logic [9:0] store [N][16];
   int         head [N];
   int         cnt  [N];

   logic [9:0] exp_q[$];
   logic [1:0] exp_id_q[$];
   int         fire_log[$];
   int         acc_cyc[$];

   int   cyc = 0;
   int   n_acc, n_stall, stall_left, stall_at, rdy_mode;
   bit   stalled_prev;
   logic [9:0] prev_beat;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // ---------------- driver ----------------
   task automatic drive();
      for (int i = 0; i < N; i++) begin
         req_valid[i]         = (cnt[i] > 0);
         req_data[i*DW +: DW] = (cnt[i] > 0) ? store[i][head[i]][DW-1:0] : '0;
         req_mode[2*i +: 2]   = (cnt[i] > 0) ? store[i][head[i]][DW+1:DW] : '0;
      end
   endtask

   task automatic load(input int id, input int n, input logic [7:0] base, input logic [1:0] md);
      for (int k = 0; k < n; k++) store[id][k] = {md, base + 8'(k)};
      cnt[id]  = n;
      head[id] = 0;
   endtask

   // Reference model: round-robin over requesters with beats left, each grant
   // taking up to bl beats; running dry ends the grant early.
   task automatic predict(input int bl);
      int rem [N];
      int pos [N];
      int ptr;
      int id;
      bit any;
      ptr = 0;
      for (int i = 0; i < N; i++) begin rem[i] = cnt[i]; pos[i] = 0; end
      any = 1'b1;
      while (any) begin
         id = -1;
         for (int k = 0; k < N; k++)
            if (id < 0 && rem[(ptr + k) % N] > 0) id = (ptr + k) % N;
         if (id < 0) any = 1'b0;
         else begin
            for (int b = 0; b < bl && rem[id] > 0; b++) begin
               exp_q.push_back(store[id][pos[id]]);
               exp_id_q.push_back(2'(id));
               pos[id]++;
               rem[id]--;
            end
            ptr = (id + 1) % N;
         end
      end
   endtask

   // ---------------- one clock of monitoring + driving ----------------
   task automatic cycle();
      bit fired [N];
      @(negedge clk);
      cyc++;
      if (stalled_prev) begin
         check("hold_valid", 32'(valid_out), 32'd1);
         check("hold_beat", 32'({mode_out, data_out}), 32'(prev_beat));
      end
      stalled_prev = valid_out && !ready_in;
      prev_beat    = {mode_out, data_out};
      if (valid_out && !ready_in) begin
         n_stall++;
         check("stall_ready", 32'(req_ready), 32'd0);
      end
      check("ready_onehot", 32'($countones(req_ready) <= 1), 32'd1);
      for (int i = 0; i < N; i++) begin
         fired[i] = req_valid[i] && req_ready[i];
         if (fired[i]) begin
            fire_log.push_back(i);
            if (exp_id_q.size() == 0) check("fire_extra", 32'(i), 32'hFF);
            else check("fire_id", 32'(i), 32'(exp_id_q.pop_front()));
         end
      end
      if (valid_out && ready_in) begin
         acc_cyc.push_back(cyc);
         n_acc++;
         if (exp_q.size() == 0) check("beat_extra", 32'({mode_out, data_out}), 32'hDEAD);
         else check("beat", 32'({mode_out, data_out}), 32'(exp_q.pop_front()));
         if (n_acc == stall_at) stall_left = 5;
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++)
         if (fired[i]) begin head[i]++; cnt[i]--; end
      if (stall_left > 0) begin ready_in = 1'b0; stall_left--; end
      else if (rdy_mode == 1) ready_in = ($urandom_range(0, 3) != 0);
      else ready_in = 1'b1;
      drive();
   endtask

   task automatic run(input string tag, input int max_cyc);
      int c;
      c = 0;
      while ((exp_q.size() > 0 || exp_id_q.size() > 0) && c < max_cyc) begin
         cycle();
         c++;
      end
      check({tag, "_drain"}, 32'(exp_q.size() + exp_id_q.size()), 32'd0);
      repeat (3) cycle();
   endtask

   task automatic do_reset(input bit expect_pending);
      @(negedge clk);
      #2;
      if (expect_pending) check("pre_reset_valid", 32'(valid_out), 32'd1);
      rst = 1'b0;
      for (int i = 0; i < N; i++) begin cnt[i] = 0; head[i] = 0; end
      exp_q.delete(); exp_id_q.delete(); fire_log.delete(); acc_cyc.delete();
      n_acc = 0; n_stall = 0; stall_left = 0; stall_at = -1; rdy_mode = 0;
      stalled_prev = 1'b0;
      drive();
      ready_in = 1'b1;
      #1;
      check("rst_valid", 32'(valid_out), 32'd0);
      check("rst_data", 32'(data_out), 32'd0);
      check("rst_mode", 32'(mode_out), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_grant", 32'(grant_id), 32'd0);
      check("rst_ready", 32'(req_ready), 32'd0);
      check("rst_valid1", 32'(valid_out1), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      int s6_fire[$];
      int s6_cyc[$];
      logic [9:0] s6_beat[$];
      int ptr, id, t;

      rst = 1'b0; req_valid = '0; req_data = '0; req_mode = '0; ready_in = 1'b1;
      for (int i = 0; i < N; i++) begin cnt[i] = 0; head[i] = 0; end

      // Single requester, two full bursts with a one-cycle idle gap.
      do_reset(1'b0);
      load(0, 8, 8'h10, 2'd2);
      predict(BL);
      drive();
      run("s1", 100);
      check("s1_beats", 32'(acc_cyc.size()), 32'd8);
      if (acc_cyc.size() == 8) begin
         check("s1_tput_a", 32'(acc_cyc[3] - acc_cyc[0]), 32'd3);
         check("s1_gap", 32'(acc_cyc[4] - acc_cyc[3]), 32'd2);
         check("s1_tput_b", 32'(acc_cyc[7] - acc_cyc[4]), 32'd3);
      end

      // All four requesters continuously valid.
      do_reset(1'b0);
      for (int i = 0; i < N; i++) load(i, 8, 8'(8'h40 + 8'(i * 16)), 2'(i));
      predict(BL);
      drive();
      run("s2", 200);
      check("s2_wrap", 32'((fire_log.size() > 16) ? fire_log[16] : 99), 32'd0);
      check("s2_last_of_3", 32'((fire_log.size() > 15) ? fire_log[15] : 99), 32'd3);

      // Output stall for five cycles mid-burst.
      do_reset(1'b0);
      load(0, 4, 8'h60, 2'd1);
      stall_at = 2;
      predict(BL);
      drive();
      run("s3", 100);
      check("s3_stall_cycles", 32'(n_stall), 32'd5);

      // Requester 1 runs dry after two beats; requester 2 follows.
      do_reset(1'b0);
      load(1, 2, 8'h20, 2'd3);
      load(2, 4, 8'h30, 2'd0);
      predict(BL);
      drive();
      run("s4", 100);
      check("s4_n_beats", 32'(fire_log.size()), 32'd6);
      check("s4_third_id", 32'((fire_log.size() > 2) ? fire_log[2] : 99), 32'd2);

      // Reset mid-burst with a beat pending, then restart from requester 0.
      do_reset(1'b0);
      load(0, 4, 8'h70, 2'd1);
      load(2, 2, 8'h80, 2'd2);
      predict(BL);
      drive();
      for (int c = 0; c < 20 && n_acc < 1; c++) cycle();
      do_reset(1'b1);
      load(0, 3, 8'h50, 2'd3);
      load(2, 3, 8'h90, 2'd1);
      predict(BL);
      drive();
      run("s5", 100);
      check("s5_first_id", 32'((fire_log.size() > 0) ? fire_log[0] : 99), 32'd0);

      // Randomized rounds with random backpressure.
      for (int r = 0; r < 6; r++) begin
         do_reset(1'b0);
         for (int i = 0; i < N; i++) begin
            cnt[i] = $urandom_range(0, 9);
            head[i] = 0;
            for (int k = 0; k < cnt[i]; k++) store[i][k] = 10'($urandom);
         end
         rdy_mode = 1;
         predict(BL);
         drive();
         run("rand", 600);
      end

      // Single-beat bursts on the BURST_LEN=1 instance, requesters 0 and 3.
      do_reset(1'b0);
      req_valid = 4'b1001;
      req_data = '0;
      req_data[7:0] = 8'hA0;
      req_data[31:24] = 8'hA3;
      req_mode = 8'b11_00_00_01;
      for (t = 0; t < 14; t++) begin
         @(negedge clk);
         for (int i = 0; i < N; i++)
            if (req_valid[i] && req_ready1[i]) begin s6_fire.push_back(i); s6_cyc.push_back(t); end
         if (valid_out1 && ready_in) s6_beat.push_back({mode_out1, data_out1});
      end
      req_valid = '0;
      check("s6_fires", 32'(s6_fire.size() >= 6), 32'd1);
      check("s6_beats", 32'(s6_beat.size() >= 6), 32'd1);
      ptr = 0;
      for (int k = 0; k < 6 && k < s6_fire.size() && k < s6_beat.size(); k++) begin
         id = (ptr == 0) ? 0 : 3;
         if (ptr > 3) id = 0;
         check("s6_id", 32'(s6_fire[k]), 32'(id));
         check("s6_beat", 32'(s6_beat[k]), (id == 0) ? 32'h1A0 : 32'h3A3);
         if (k > 0) check("s6_spacing", 32'(s6_cyc[k] - s6_cyc[k-1]), 32'd2);
         ptr = (id + 1) % N;
      end

      $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
      $finish;
   end

endmodule
